wsg_mixer: RTL

//  Consumer of the WSG time-multiplexed output bus (8 slots of {vol[3:0],wave[3:0]}, 16 pxclk each, 128-clk frame).

---
 rtl/wsg_mixer_pkg.sv | 38 +++
 rtl/wsg_sd_dac.sv | 37 +++
 rtl/wsg_mixer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/wsg_mixer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wsg_mixer_pkg
//  Description : Shared constants, slot type and channel-product helper for
//                the WSG output-bus mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
package wsg_mixer_pkg;

    localparam int NUM_CH   = 8;
    localparam int SLOT_LEN = 16;
    localparam int PHASE_W  = $clog2(NUM_CH * SLOT_LEN);

    localparam logic [3:0]         CAP_SUB   = 4'hC;
    localparam logic [3:0]         ACC_SUB   = 4'hD;
    localparam logic [PHASE_W-1:0] OUT_PHASE = 7'h7E;
    localparam int                 WAVE_MID  = 8;

    localparam logic signed [19:0] PCM_MAX = 20'sd32767;
    localparam logic signed [19:0] PCM_MIN = -20'sd32768;

    // One slot of the WSG bus
    typedef struct packed {
        logic [3:0] vol;
        logic [3:0] wave;
    } wsg_slot_t;

    // Signed contribution of one channel: vol * (wave - midpoint), -120..+105
    function automatic logic signed [8:0] chan_product(input wsg_slot_t s);
        logic signed [8:0] v;
        logic signed [8:0] w;
        v = $signed({5'b0, s.vol});
        w = $signed({5'b0, s.wave}) - $signed(9'(WAVE_MID));
        return v * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wsg_sd_dac.sv
`default_nettype none
// ============================================================================
//  Module      : wsg_sd_dac
//  Description : First-order sigma-delta modulator turning the signed PCM
//                sample into a 1-bit pin-DAC stream (carry of offset adder).
//  Revision    : 1.0 - initial release
// ============================================================================
module wsg_sd_dac (
    input  logic        pxclk,
    input  logic        RESET,
    input  logic [15:0] pcm_in,
    output logic        dac_out
);

    logic [15:0] sd_acc_q, sd_acc_d;
    logic        dac_q, dac_d;

    // Offset-binary accumulate; the carry out is the output bit
    always_comb begin
        {dac_d, sd_acc_d} = {1'b0, sd_acc_q} + {1'b0, pcm_in ^ 16'h8000};
    end

    // Modulator state
    always_ff @(posedge pxclk or posedge RESET) begin
        if (RESET) begin
            sd_acc_q <= '0;
            dac_q    <= 1'b0;
        end else begin
            sd_acc_q <= sd_acc_d;
            dac_q    <= dac_d;
        end
    end

    assign dac_out = dac_q;

endmodule
`default_nettype wire

// File: rtl/wsg_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : wsg_mixer
//  Description : Captures the 8 time-multiplexed WSG slots, mixes them into
//                one saturated, optionally low-pass filtered 16-bit PCM
//                sample per 128-clock frame and drives a sigma-delta DAC.
//  Revision    : 1.0 - initial release
// ============================================================================
module wsg_mixer
    import wsg_mixer_pkg::*;
#(
    parameter int                GAIN_SHIFT = 5,
    parameter int                LPF_SHIFT  = 0,
    parameter logic [NUM_CH-1:0] CH_MASK    = 8'hFF
) (
    input  logic        pxclk,
    input  logic        RESET,
    input  logic [7:0]  c99raw_in,
    input  logic        phase_sync,
    input  logic        mute,
    output logic [15:0] pcm_out,
    output logic        pcm_valid,
    output logic        clip,
    output logic        dac_out
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic signed [8:0]  prod_q, prod_d;
    logic signed [10:0] acc_q, acc_d;
    logic signed [17:0] y_q, y_d;
    logic [15:0]        pcm_q, pcm_d;
    logic               pcm_valid_q, pcm_valid_d;
    logic               clip_q, clip_d;

    logic [2:0]         slot;
    logic [3:0]         sub;
    logic signed [10:0] prod_ext;
    logic signed [19:0] scaled;
    logic               sat_hi, sat_lo;
    logic signed [15:0] x;
    logic signed [17:0] diff;
    logic signed [17:0] y_next;

    assign slot     = phase_q[6:4];
    assign sub      = phase_q[3:0];
    assign prod_ext = {{2{prod_q[8]}}, prod_q};

    // Frame phase: free-running, phase_sync realigns to the WSG counter
    always_comb begin
        phase_d = phase_sync ? 7'd1 : phase_q + 7'd1;
    end

    // Per-slot capture and frame accumulation (slot 0 restarts the sum)
    always_comb begin
        prod_d = prod_q;
        acc_d  = acc_q;
        if (sub == CAP_SUB) begin
            prod_d = (mute || !CH_MASK[slot]) ? 9'sd0 : chan_product(c99raw_in);
        end
        if (sub == ACC_SUB) begin
            acc_d = (slot == 3'd0) ? prod_ext : acc_q + prod_ext;
        end
    end

    // Gain, saturation and one-pole low-pass on the completed frame sum
    always_comb begin
        scaled = {{9{acc_q[10]}}, acc_q} <<< GAIN_SHIFT;
        sat_hi = scaled > PCM_MAX;
        sat_lo = scaled < PCM_MIN;
        if (sat_hi) begin
            x = PCM_MAX[15:0];
        end else if (sat_lo) begin
            x = PCM_MIN[15:0];
        end else begin
            x = scaled[15:0];
        end
        diff   = {{2{x[15]}}, x} - y_q;
        y_next = y_q + (diff >>> LPF_SHIFT);
    end

    // Sample update at the end of the output phase; strobe lasts one clock
    always_comb begin
        y_d         = y_q;
        pcm_d       = pcm_q;
        clip_d      = clip_q;
        pcm_valid_d = (phase_q == OUT_PHASE);
        if (phase_q == OUT_PHASE) begin
            y_d    = y_next;
            pcm_d  = y_next[15:0];
            clip_d = sat_hi | sat_lo;
        end
    end

    // Mixer state
    always_ff @(posedge pxclk or posedge RESET) begin
        if (RESET) begin
            phase_q     <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
            clip_q      <= clip_d;
        end
    end

    assign pcm_out   = pcm_q;
    assign pcm_valid = pcm_valid_q;
    assign clip      = clip_q;

    wsg_sd_dac u_sd_dac (
        .pxclk   (pxclk),
        .RESET   (RESET),
        .pcm_in  (pcm_q),
        .dac_out (dac_out)
    );

endmodule
`default_nettype wire
